pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV64I pipeline. Merges load-use stall and branch redirect

---
 rtl/core_pkg.sv | 50 +++++
 rtl/perf_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: pipeline-control FSM states and the per-stage
// stall/flush control bundle.
package core_pkg;

    typedef enum logic [1:0] {
        PC_RUN   = 2'd0,
        PC_DWAIT = 2'd1,
        PC_HALT  = 2'd2
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic StallF;
        logic StallD;
        logic StallE;
        logic StallM;
        logic FlushD;
        logic FlushE;
        logic FlushW;
    } pipe_ctl_t;

    // Canned control patterns, named for the situation that produces them.
    localparam pipe_ctl_t CTL_NONE     = '{StallF: 1'b0, StallD: 1'b0, StallE: 1'b0, StallM: 1'b0,
                                           FlushD: 1'b0, FlushE: 1'b0, FlushW: 1'b0};
    localparam pipe_ctl_t CTL_RESET    = '{StallF: 1'b0, StallD: 1'b0, StallE: 1'b0, StallM: 1'b0,
                                           FlushD: 1'b1, FlushE: 1'b1, FlushW: 1'b1};
    localparam pipe_ctl_t CTL_HALT     = '{StallF: 1'b1, StallD: 1'b1, StallE: 1'b1, StallM: 1'b1,
                                           FlushD: 1'b0, FlushE: 1'b0, FlushW: 1'b1};
    localparam pipe_ctl_t CTL_BACKEND  = '{StallF: 1'b1, StallD: 1'b1, StallE: 1'b1, StallM: 1'b1,
                                           FlushD: 1'b0, FlushE: 1'b0, FlushW: 1'b1};
    localparam pipe_ctl_t CTL_REDIRECT = '{StallF: 1'b0, StallD: 1'b0, StallE: 1'b0, StallM: 1'b0,
                                           FlushD: 1'b1, FlushE: 1'b1, FlushW: 1'b0};
    localparam pipe_ctl_t CTL_LOADUSE  = '{StallF: 1'b1, StallD: 1'b1, StallE: 1'b0, StallM: 1'b0,
                                           FlushD: 1'b0, FlushE: 1'b1, FlushW: 1'b0};
    localparam pipe_ctl_t CTL_FETCHW   = '{StallF: 1'b1, StallD: 1'b0, StallE: 1'b0, StallM: 1'b0,
                                           FlushD: 1'b1, FlushE: 1'b0, FlushW: 1'b0};

    // Front-end hazard resolution (everything below the backend wait).
    function automatic pipe_ctl_t frontend_ctl(input logic pc_src, input logic lw_stall,
                                               input logic imem_rdy);
        if (pc_src)
            return CTL_REDIRECT;
        else if (lw_stall)
            return CTL_LOADUSE;
        else if (!imem_rdy)
            return CTL_FETCHW;
        else
            return CTL_NONE;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter; wraps at 2^PERF_W.
module perf_counter #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    // Count one per cycle with inc high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc)
            count <= count + PERF_W'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with D-mem wait timeout.
// Optional performance counters: define PIPE_CTRL_PERF_EN.
module pipeline_ctrl
    import core_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 255,
    parameter int unsigned PERF_W       = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lwStall_D,
    input  logic PCSrc_E,
    input  logic imem_ready,
    input  logic dmem_req_M,
    input  logic dmem_ready,
    output logic StallF,
    output logic StallD,
    output logic StallE,
    output logic StallM,
    output logic FlushD,
    output logic FlushE,
    output logic FlushW,
    output logic halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt,
    output logic [PERF_W-1:0] perf_dwait_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(DMEM_TIMEOUT);

    if (DMEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("pipeline_ctrl: DMEM_TIMEOUT must be >= 1");
    end
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("pipeline_ctrl: PERF_W must be >= 1");
    end

    pipe_ctrl_state_t state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    pipe_ctl_t        ctl;
    logic             dmem_miss;

    assign dmem_miss = dmem_req_M & ~dmem_ready;

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PC_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state and prioritised stage controls (Mealy on the miss).
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ctl          = CTL_NONE;

        case (state)
            PC_RUN: begin
                if (dmem_miss) begin
                    state_nxt    = PC_DWAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            PC_DWAIT: begin
                if (dmem_ready) begin
                    state_nxt    = PC_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TIMEOUT_V) begin
                    state_nxt = PC_HALT;
                end else if (wait_cnt != '1) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            PC_HALT: state_nxt = PC_HALT;
            default: begin
                state_nxt    = PC_RUN;
                wait_cnt_nxt = '0;
            end
        endcase

        if (state == PC_HALT)
            ctl = CTL_HALT;
        else if (dmem_miss)
            ctl = CTL_BACKEND;
        else
            ctl = frontend_ctl(PCSrc_E, lwStall_D, imem_ready);

        // Reset drives bubbles into D/E/W independently of the registered state.
        if (!rst_n)
            ctl = CTL_RESET;
    end

    assign StallF = ctl.StallF;
    assign StallD = ctl.StallD;
    assign StallE = ctl.StallE;
    assign StallM = ctl.StallM;
    assign FlushD = ctl.FlushD;
    assign FlushE = ctl.FlushE;
    assign FlushW = ctl.FlushW;
    assign halted = (state == PC_HALT);

`ifdef PIPE_CTRL_PERF_EN
    perf_counter #(.PERF_W(PERF_W)) u_perf_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctl.StallF),
        .count (perf_stall_cnt)
    );

    perf_counter #(.PERF_W(PERF_W)) u_perf_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctl.FlushE & rst_n),
        .count (perf_flush_cnt)
    );

    perf_counter #(.PERF_W(PERF_W)) u_perf_dwait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state == PC_DWAIT),
        .count (perf_dwait_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a default-timeout instance and a
// DMEM_TIMEOUT=3 / PERF_W=4 instance share the same stimulus.
`timescale 1ns/1ps
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lwStall_D = 1'b0, PCSrc_E = 1'b0, imem_ready = 1'b1;
    logic dmem_req_M = 1'b0, dmem_ready = 1'b1;

    logic sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a, h_a;
    logic sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b, h_b;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] ps_a, pf_a, pd_a;
    logic [3:0]  ps_b, pf_b, pd_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n), .lwStall_D(lwStall_D), .PCSrc_E(PCSrc_E),
        .imem_ready(imem_ready), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .StallM(sm_a),
        .FlushD(fd_a), .FlushE(fe_a), .FlushW(fw_a), .halted(h_a)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cnt(ps_a), .perf_flush_cnt(pf_a), .perf_dwait_cnt(pd_a)
`endif
    );

    pipeline_ctrl #(.DMEM_TIMEOUT(3), .PERF_W(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .lwStall_D(lwStall_D), .PCSrc_E(PCSrc_E),
        .imem_ready(imem_ready), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .StallM(sm_b),
        .FlushD(fd_b), .FlushE(fe_b), .FlushW(fw_b), .halted(h_b)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cnt(ps_b), .perf_flush_cnt(pf_b), .perf_dwait_cnt(pd_b)
`endif
    );

    // {halted, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [7:0] E_IDLE = 8'b0_0000_000;
    localparam logic [7:0] E_RST  = 8'b0_0000_111;
    localparam logic [7:0] E_LU   = 8'b0_1100_010;
    localparam logic [7:0] E_RD   = 8'b0_0000_110;
    localparam logic [7:0] E_BW   = 8'b0_1111_001;
    localparam logic [7:0] E_HALT = 8'b1_1111_001;
    localparam logic [7:0] E_FW   = 8'b0_1000_100;

    typedef struct {
        string      tag;
        logic [7:0] em;
        bit         cm;
        logic [7:0] et;
        bit         ct;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue its expectation.
    task automatic step(input string tag, input logic rn, input logic lw, input logic pc,
                        input logic im, input logic rq, input logic rd,
                        input logic [7:0] em, input bit cm, input logic [7:0] et, input bit ct);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; lwStall_D = lw; PCSrc_E = pc;
        imem_ready = im; dmem_req_M = rq; dmem_ready = rd;
        e.tag = tag; e.em = em; e.cm = cm; e.et = et; e.ct = ct;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string tag, input logic [7:0] em, input bit cm,
                        input logic [7:0] et, input bit ct);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, em, cm, et, ct);
    endtask

    // Outputs are compared mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cm)
                check({e.tag, "/a"}, {24'd0, h_a, sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a}, {24'd0, e.em});
            if (e.ct)
                check({e.tag, "/b"}, {24'd0, h_b, sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b}, {24'd0, e.et});
        end
    end

    initial begin
        // T1: reset held three cycles, then idle
        for (int i = 0; i < 3; i++)
            step("t1_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_RST, 1, E_RST, 1);
        idle("t1_idle", E_IDLE, 1, E_IDLE, 1);

        // T2: load-use for one cycle, then load-use with redirect
        step("t2_lu", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, E_LU, 1, E_LU, 1);
        idle("t2_after", E_IDLE, 1, E_IDLE, 1);
        step("t2_lu_rd", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, E_RD, 1, E_RD, 1);
        step("t2_rd_fw", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, E_RD, 1, E_RD, 1);
        step("t2_rdy_noreq", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_IDLE, 1, E_IDLE, 1);

        // T3: four D-mem wait cycles with hazards masked, release with redirect
        step("t3_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_RST, 1, E_RST, 1);
        idle("t3_idle", E_IDLE, 1, E_IDLE, 1);
        step("t3_w1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BW, 1, E_BW, 1);
        step("t3_w2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_BW, 1, E_BW, 1);
        step("t3_w3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, E_BW, 1, E_BW, 1);
        step("t3_w4", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_BW, 1, E_BW, 0);
        step("t3_rel", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, E_RD, 1, E_HALT, 0);
        idle("t3_run", E_IDLE, 1, E_HALT, 0);
`ifdef PIPE_CTRL_PERF_EN
        @(negedge clk); #1;
        check("t6_dwait", pd_a, 32'd4);
        check("t6_stall", ps_a, 32'd4);
        check("t6_flush", pf_a, 32'd1);
`endif
        // back in RUN: a single miss followed by completion
        step("t3_miss2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BW, 1, E_HALT, 0);
        step("t3_rel2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, E_LU, 1, E_HALT, 0);

        // T4: timeout of 3 on dut_to leads to sticky halt
        step("t4_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_RST, 1, E_RST, 1);
        idle("t4_idle", E_IDLE, 1, E_IDLE, 1);
        for (int i = 0; i < 4; i++)
            step("t4_wait", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BW, 1, E_BW, 1);
        step("t4_halt", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BW, 1, E_HALT, 1);
        step("t4_tog1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, E_RD, 0, E_HALT, 1);
        step("t4_tog2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, E_IDLE, 0, E_HALT, 1);
        step("t4_tog3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_RD, 0, E_HALT, 1);
        step("t4_rst2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_RST, 1, E_RST, 1);
        idle("t4_run", E_IDLE, 1, E_IDLE, 1);
        step("t4_hit", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, E_IDLE, 1, E_IDLE, 1);

        // reset in the middle of a wait returns to RUN without halting
        step("mid_w1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BW, 1, E_BW, 1);
        step("mid_w2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BW, 1, E_BW, 1);
        step("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_RST, 1, E_RST, 1);
        step("mid_w3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BW, 1, E_BW, 1);
        step("mid_w4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BW, 1, E_BW, 1);
        step("mid_w5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_BW, 1, E_BW, 1);
        step("mid_rel", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, E_IDLE, 1, E_IDLE, 1);

        // T5: fetch wait, then fetch wait coincident with load-use
        step("t5_fw1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_FW, 1, E_FW, 1);
        step("t5_fw2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_FW, 1, E_FW, 1);
        step("t5_fw_lu", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_LU, 1, E_LU, 1);
        idle("t5_idle", E_IDLE, 1, E_IDLE, 1);

        // T6: 17 stall cycles on the 4-bit counters wrap to 1
        step("t6_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_RST, 1, E_RST, 1);
        for (int i = 0; i < 17; i++)
            step("t6_lu", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, E_LU, 1, E_LU, 1);
        idle("t6_idle", E_IDLE, 1, E_IDLE, 1);
`ifdef PIPE_CTRL_PERF_EN
        @(negedge clk); #1;
        check("t6_wrap_stall", {28'd0, ps_b}, 32'd1);
        check("t6_wrap_flush", {28'd0, pf_b}, 32'd1);
        check("t6_wide_stall", ps_a, 32'd17);
        check("t6_wrap_dwait", {28'd0, pd_b}, 32'd0);
`endif

        @(negedge clk); #1;
        check("drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
